// File: rtl/lx32_arch_pkg.sv
// RV32I architectural constants: XLEN, base opcodes and the shared immediate extractors.
package lx32_arch_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [31:0] instr_t;
  typedef logic [6:0]  opcode_t;

  localparam opcode_t OPC_LUI      = 7'b0110111;
  localparam opcode_t OPC_AUIPC    = 7'b0010111;
  localparam opcode_t OPC_JAL      = 7'b1101111;
  localparam opcode_t OPC_JALR     = 7'b1100111;
  localparam opcode_t OPC_BRANCH   = 7'b1100011;
  localparam opcode_t OPC_LOAD     = 7'b0000011;
  localparam opcode_t OPC_STORE    = 7'b0100011;
  localparam opcode_t OPC_OP_IMM   = 7'b0010011;
  localparam opcode_t OPC_OP       = 7'b0110011;
  localparam opcode_t OPC_MISC_MEM = 7'b0001111;
  localparam opcode_t OPC_SYSTEM   = 7'b1110011;

  function automatic logic [XLEN-1:0] get_i_imm(input instr_t i);
    return {{(XLEN-12){i[31]}}, i[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] get_s_imm(input instr_t i);
    return {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] get_b_imm(input instr_t i);
    return {{(XLEN-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] get_u_imm(input instr_t i);
    return {{(XLEN-32){i[31]}}, i[31:12], 12'b0};
  endfunction

  function automatic logic [XLEN-1:0] get_j_imm(input instr_t i);
    return {{(XLEN-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/lx32_decode_pkg.sv
// Decode-stage types: immediate format codes and the queued decoded-entry layout.
package lx32_decode_pkg;

  import lx32_arch_pkg::*;

  typedef enum logic [2:0] {
    IMM_R   = 3'd0,
    IMM_I   = 3'd1,
    IMM_S   = 3'd2,
    IMM_B   = 3'd3,
    IMM_U   = 3'd4,
    IMM_J   = 3'd5,
    IMM_ILL = 3'd7
  } imm_fmt_e;

  typedef struct packed {
    instr_t          instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } dec_entry_t;

endpackage

// File: rtl/lx32_imm_sel.sv
// Combinational opcode classification and sign-extended immediate selection.
module lx32_imm_sel
  import lx32_arch_pkg::*;
  import lx32_decode_pkg::*;
(
  input  instr_t          i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt,
  output logic            o_illegal
);

  // Every listed opcode ends in 2'b11, so compressed encodings fall to the default.
  always_comb begin
    o_imm     = '0;
    o_fmt     = IMM_ILL;
    o_illegal = 1'b1;
    case (i_instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        o_imm     = get_u_imm(i_instr);
        o_fmt     = IMM_U;
        o_illegal = 1'b0;
      end
      OPC_JAL: begin
        o_imm     = get_j_imm(i_instr);
        o_fmt     = IMM_J;
        o_illegal = 1'b0;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: begin
        o_imm     = get_i_imm(i_instr);
        o_fmt     = IMM_I;
        o_illegal = 1'b0;
      end
      OPC_STORE: begin
        o_imm     = get_s_imm(i_instr);
        o_fmt     = IMM_S;
        o_illegal = 1'b0;
      end
      OPC_BRANCH: begin
        o_imm     = get_b_imm(i_instr);
        o_fmt     = IMM_B;
        o_illegal = 1'b0;
      end
      OPC_OP: begin
        o_fmt     = IMM_R;
        o_illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lx32_decode_queue.sv
// Decode-stage FIFO: decodes at enqueue and buffers entries between fetch and execute.
module lx32_decode_queue
  import lx32_arch_pkg::*;
  import lx32_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  instr_t          in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output instr_t          out_instr_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_imm_o,
  output imm_fmt_e        out_fmt_o,
  output logic            out_illegal_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  dec_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [XLEN-1:0]  w_imm;
  imm_fmt_e         w_fmt;
  logic             w_illegal;
  dec_entry_t       w_in_entry;
  dec_entry_t       w_head;
  logic             w_push;
  logic             w_pop;

  lx32_imm_sel u_imm_sel (
    .i_instr   (in_instr_i),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_illegal)
  );

  // Ready looks only at registered state so no path exists from out_ready_i.
  assign in_ready_o  = (r_count < FULL_CNT) & ~rst;
  assign out_valid_o = (r_count != '0) & ~rst;
  assign w_push      = in_valid_i & in_ready_o & ~flush_i;
  assign w_pop       = out_valid_o & out_ready_i & ~flush_i;

  assign w_in_entry = '{
    instr:   in_instr_i,
    pc:      in_pc_i,
    imm:     w_imm,
    fmt:     w_fmt,
    illegal: w_illegal
  };

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
  end

  always_comb begin
    w_head = '0;
    if (out_valid_o) w_head = r_mem[r_rd_ptr];
    out_instr_o   = w_head.instr;
    out_pc_o      = w_head.pc;
    out_imm_o     = w_head.imm;
    out_fmt_o     = w_head.fmt;
    out_illegal_o = w_head.illegal;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(w_push && r_count == FULL_CNT));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(w_pop && r_count == '0));

endmodule
